// File: rtl/iter_divider_pkg.sv
// ============================================================================
//  Module : iter_divider_pkg
//  Shared definitions for the iterative divider and its users.
//   - div_state_e : FSM state encodings (2-bit).
//   - div_op_t    : DIV_OP field layout {in_signed, in_rem}, shared with the
//                   ID decoder and the ds_to_es bus.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package iter_divider_pkg;

    typedef enum logic [1:0] {
        DIV_S_IDLE = 2'd0,
        DIV_S_CALC = 2'd1,
        DIV_S_FIX  = 2'd2,
        DIV_S_DONE = 2'd3
    } div_state_e;

    localparam int DIV_OP_W          = 2;
    localparam int DIV_OP_SIGNED_BIT = 1;
    localparam int DIV_OP_REM_BIT    = 0;

    typedef struct packed {
        logic is_signed;   // two's-complement operands
        logic rem;         // return remainder instead of quotient
    } div_op_t;

endpackage

`default_nettype wire

// File: rtl/iter_divider_step.sv
// ============================================================================
//  Module : iter_divider_step
//  One combinational restoring-division step on magnitudes.
//  Ports:
//   rem_i  / rem_o  : partial remainder in / out (always < dvsr_i)
//   quo_i  / quo_o  : dividend bits being shifted out, quotient bits shifted in
//   dvsr_i          : divisor magnitude (non-zero)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ok;

    assign w_shift = {rem_i, quo_i[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, dvsr_i};
    assign w_ok    = ~w_diff[WIDTH];

    assign rem_o = w_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], w_ok};

endmodule

`default_nettype wire

// File: rtl/iter_divider.sv
// ============================================================================
//  Module : iter_divider
//  Iterative restoring divider (DIV/MOD, signed/unsigned) with valid/ready
//  handshakes, flush and defined divide-by-zero results.
//  Ports:
//   clk, reset (sync, active-high), flush
//   in_valid/in_ready, in_signed, in_rem, in_dividend, in_divisor
//   out_valid/out_ready, out_result, out_div_by_zero, busy
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_LOG2 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic             in_rem,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_div_by_zero,
    output logic             busy
);

    localparam int STEPS = WIDTH / RADIX_LOG2;
    localparam int CNT_W = $clog2(STEPS + 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             rem_sel_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             dbz_q;

    div_op_t          w_op;
    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH-1:0] w_fix_quo;
    logic [WIDTH-1:0] w_fix_rem;

    assign w_op = '{is_signed: in_signed, rem: in_rem};

    // Magnitudes; |MIN| wraps to MIN, which is the correct unsigned magnitude.
    assign w_abs_dvd = (w_op.is_signed && in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
    assign w_abs_dvs = (w_op.is_signed && in_divisor[WIDTH-1])  ? -in_divisor  : in_divisor;

    assign w_fix_quo = neg_quo_q ? -quo_q : quo_q;
    assign w_fix_rem = neg_rem_q ? -rem_q : rem_q;

    // Chain of RADIX_LOG2 restoring steps evaluated each CALC cycle.
    logic [RADIX_LOG2:0][WIDTH-1:0] w_rem;
    logic [RADIX_LOG2:0][WIDTH-1:0] w_quo;

    assign w_rem[0] = rem_q;
    assign w_quo[0] = quo_q;

    generate
        for (genvar g = 0; g < RADIX_LOG2; g++) begin : g_step
            iter_divider_step #(
                .WIDTH (WIDTH)
            ) u_step (
                .rem_i  (w_rem[g]),
                .quo_i  (w_quo[g]),
                .dvsr_i (dvsr_q),
                .rem_o  (w_rem[g+1]),
                .quo_o  (w_quo[g+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DIV_S_IDLE;
            count_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            rem_sel_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            dbz_q        <= 1'b0;
        end else if (flush) begin
            // Result registers keep their (don't-care) contents; only the
            // handshake state is abandoned.
            state_q     <= DIV_S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_S_IDLE: begin
                    if (in_valid) begin
                        rem_sel_q <= w_op.rem;
                        if (in_divisor == '0) begin
                            out_result_q <= w_op.rem ? in_dividend : '1;
                            dbz_q        <= 1'b1;
                            out_valid_q  <= 1'b1;
                            state_q      <= DIV_S_DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= w_abs_dvd;
                            dvsr_q    <= w_abs_dvs;
                            neg_quo_q <= w_op.is_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
                            neg_rem_q <= w_op.is_signed & in_dividend[WIDTH-1];
                            count_q   <= CNT_W'(STEPS);
                            state_q   <= DIV_S_CALC;
                        end
                    end
                end
                DIV_S_CALC: begin
                    rem_q   <= w_rem[RADIX_LOG2];
                    quo_q   <= w_quo[RADIX_LOG2];
                    count_q <= count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_q <= DIV_S_FIX;
                    end
                end
                DIV_S_FIX: begin
                    out_result_q <= rem_sel_q ? w_fix_rem : w_fix_quo;
                    dbz_q        <= 1'b0;
                    out_valid_q  <= 1'b1;
                    state_q      <= DIV_S_DONE;
                end
                DIV_S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= DIV_S_IDLE;
                    end
                end
                default: begin
                    state_q     <= DIV_S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = (state_q == DIV_S_IDLE) && !flush;
    assign busy            = (state_q != DIV_S_IDLE);
    assign out_valid       = out_valid_q;
    assign out_result      = out_result_q;
    assign out_div_by_zero = dbz_q;

endmodule

`default_nettype wire
